// File: rtl/wb_stage_if.sv
// MEM->WB handshake bundle: MEM-stage fields and RAM read data in, register-file write port out.
// The optional HI/LO signals exist only when WB_HILO_EN is defined.
interface wb_stage_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              stall_mem;
    logic              stall_wb;
    logic              flush;
    logic              mem_wreg;
    logic [ADDR_W-1:0] mem_wd;
    logic [DATA_W-1:0] mem_wdata;
    logic [2:0]        mem_ltype;
    logic [1:0]        mem_baddr;
    logic              mem_llset;
    logic              mem_llclr;
    logic [DATA_W-1:0] ram_rdata;
    logic              wb_we;
    logic [ADDR_W-1:0] wb_waddr;
    logic [DATA_W-1:0] wb_wdata;
    logic              llbit_o;
`ifdef WB_HILO_EN
    logic              mem_whilo;
    logic [DATA_W-1:0] mem_hi;
    logic [DATA_W-1:0] mem_lo;
    logic [DATA_W-1:0] hi_o;
    logic [DATA_W-1:0] lo_o;
`endif

    modport master (
        output stall_mem, stall_wb, flush, mem_wreg, mem_wd, mem_wdata,
               mem_ltype, mem_baddr, mem_llset, mem_llclr, ram_rdata,
`ifdef WB_HILO_EN
        output mem_whilo, mem_hi, mem_lo,
        input  hi_o, lo_o,
`endif
        input  wb_we, wb_waddr, wb_wdata, llbit_o
    );

    modport slave (
        input  stall_mem, stall_wb, flush, mem_wreg, mem_wd, mem_wdata,
               mem_ltype, mem_baddr, mem_llset, mem_llclr, ram_rdata,
`ifdef WB_HILO_EN
        input  mem_whilo, mem_hi, mem_lo,
        output hi_o, lo_o,
`endif
        output wb_we, wb_waddr, wb_wdata, llbit_o
    );
endinterface

// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB register, load-data extraction, LL bit; 1-cycle latency, stall/flush bubbles.
// Optional HI/LO pair enabled by WB_HILO_EN.
module wb_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic     clk,
    input  logic     rst,
    wb_stage_if.slave bus
);
    localparam logic [2:0] LT_LB  = 3'd1;
    localparam logic [2:0] LT_LBU = 3'd2;
    localparam logic [2:0] LT_LH  = 3'd3;
    localparam logic [2:0] LT_LHU = 3'd4;
    localparam logic [2:0] LT_LW  = 3'd5;

    logic              r_wreg;
    logic [ADDR_W-1:0] r_wd;
    logic [DATA_W-1:0] r_wdata;
    logic [2:0]        r_ltype;
    logic [1:0]        r_baddr;
    logic              r_llset;
    logic              r_llclr;
    logic              r_llbit;

    logic              w_bubble;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [DATA_W-1:0] w_wdata;

    // A stalled MEM feeding a running WB must not replay its instruction.
    assign w_bubble = bus.flush | (bus.stall_mem & ~bus.stall_wb);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wreg  <= 1'b0;
            r_wd    <= '0;
            r_wdata <= '0;
            r_ltype <= '0;
            r_baddr <= '0;
            r_llset <= 1'b0;
            r_llclr <= 1'b0;
        end else if (w_bubble) begin
            r_wreg  <= 1'b0;
            r_wd    <= '0;
            r_wdata <= '0;
            r_ltype <= '0;
            r_baddr <= '0;
            r_llset <= 1'b0;
            r_llclr <= 1'b0;
        end else if (!bus.stall_mem) begin
            r_wreg  <= bus.mem_wreg;
            r_wd    <= bus.mem_wd;
            r_wdata <= bus.mem_wdata;
            r_ltype <= bus.mem_ltype;
            r_baddr <= bus.mem_baddr;
            r_llset <= bus.mem_llset;
            r_llclr <= bus.mem_llclr;
        end
    end

    // Bubbles carry llset/llclr=0, so the bit only moves for real instructions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_llbit <= 1'b0;
        end else if (bus.flush) begin
            r_llbit <= 1'b0;
        end else if (r_llset) begin
            r_llbit <= 1'b1;
        end else if (r_llclr) begin
            r_llbit <= 1'b0;
        end
    end

    always_comb begin
        w_byte  = bus.ram_rdata[{r_baddr, 3'b000} +: 8];
        w_half  = r_baddr[1] ? bus.ram_rdata[31:16] : bus.ram_rdata[15:0];
        w_wdata = r_wdata;
        case (r_ltype)
            LT_LB:   w_wdata = {{(DATA_W-8){w_byte[7]}}, w_byte};
            LT_LBU:  w_wdata = {{(DATA_W-8){1'b0}}, w_byte};
            LT_LH:   w_wdata = {{(DATA_W-16){w_half[15]}}, w_half};
            LT_LHU:  w_wdata = {{(DATA_W-16){1'b0}}, w_half};
            LT_LW:   w_wdata = bus.ram_rdata;
            default: w_wdata = r_wdata;
        endcase
    end

    assign bus.wb_we    = r_wreg;
    assign bus.wb_waddr = r_wd;
    assign bus.wb_wdata = w_wdata;
    assign bus.llbit_o  = bus.flush ? 1'b0 :
                          r_llset   ? 1'b1 :
                          r_llclr   ? 1'b0 : r_llbit;

`ifdef WB_HILO_EN
    logic              r_whilo;
    logic [DATA_W-1:0] r_hi_p;
    logic [DATA_W-1:0] r_lo_p;
    logic [DATA_W-1:0] r_hi;
    logic [DATA_W-1:0] r_lo;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_whilo <= 1'b0;
            r_hi_p  <= '0;
            r_lo_p  <= '0;
        end else if (w_bubble) begin
            r_whilo <= 1'b0;
            r_hi_p  <= '0;
            r_lo_p  <= '0;
        end else if (!bus.stall_mem) begin
            r_whilo <= bus.mem_whilo;
            r_hi_p  <= bus.mem_hi;
            r_lo_p  <= bus.mem_lo;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (r_whilo && !bus.flush) begin
            r_hi <= r_hi_p;
            r_lo <= r_lo_p;
        end
    end

    assign bus.hi_o = r_whilo ? r_hi_p : r_hi;
    assign bus.lo_o = r_whilo ? r_lo_p : r_lo;
`endif
endmodule

// File: tb/tb_wb_stage.sv
// Randomized + directed bench for wb_stage against a behavioural reference model.
module tb_wb_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_stage_if #(.DATA_W(32), .ADDR_W(5)) bus ();
    wb_stage #(.DATA_W(32), .ADDR_W(5)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        bit          stall_mem, stall_wb, flush, wreg, llset, llclr, whilo;
        bit [4:0]    wd;
        bit [31:0]   wdata, rdata, hi, lo;
        bit [2:0]    ltype;
        bit [1:0]    baddr;
    } in_t;

    // Reference model: the instruction sitting in WB plus architectural LL/HI/LO.
    in_t         m_wb;
    bit          m_ll;
    bit [31:0]   m_hi, m_lo;
    in_t         cur;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic in_t idle();
        in_t t;
        t = '{default: 0};
        return t;
    endfunction

    function automatic bit [31:0] exp_wdata(input bit [31:0] rd);
        int unsigned b, h;
        b = (rd >> (8 * m_wb.baddr)) & 32'hFF;
        h = (rd >> (16 * (m_wb.baddr / 2))) & 32'hFFFF;
        case (m_wb.ltype)
            3'd1:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd2:    return b;
            3'd3:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'd4:    return h;
            3'd5:    return rd;
            default: return m_wb.wdata;
        endcase
    endfunction

    task automatic model_reset();
        m_wb = idle();
        m_ll = 0;
        m_hi = 0;
        m_lo = 0;
    endtask

    task automatic compare(input string tag);
        bit exp_ll;
        if (rst) exp_ll = 0;
        else if (cur.flush) exp_ll = 0;
        else if (m_wb.llset) exp_ll = 1;
        else if (m_wb.llclr) exp_ll = 0;
        else exp_ll = m_ll;
        chk({tag, ".we"},    32'(bus.wb_we),    32'(m_wb.wreg));
        chk({tag, ".waddr"}, 32'(bus.wb_waddr), 32'(m_wb.wd));
        chk({tag, ".wdata"}, bus.wb_wdata,      exp_wdata(cur.rdata));
        chk({tag, ".llbit"}, 32'(bus.llbit_o),  32'(exp_ll));
`ifdef WB_HILO_EN
        chk({tag, ".hi"}, bus.hi_o, m_wb.whilo ? m_wb.hi : m_hi);
        chk({tag, ".lo"}, bus.lo_o, m_wb.whilo ? m_wb.lo : m_lo);
`endif
    endtask

    task automatic drive(input in_t t, input string tag);
        @(negedge clk);
        cur = t;
        bus.stall_mem = t.stall_mem; bus.stall_wb = t.stall_wb; bus.flush = t.flush;
        bus.mem_wreg = t.wreg;  bus.mem_wd = t.wd;  bus.mem_wdata = t.wdata;
        bus.mem_ltype = t.ltype; bus.mem_baddr = t.baddr;
        bus.mem_llset = t.llset; bus.mem_llclr = t.llclr; bus.ram_rdata = t.rdata;
`ifdef WB_HILO_EN
        bus.mem_whilo = t.whilo; bus.mem_hi = t.hi; bus.mem_lo = t.lo;
`endif
        #1;
        compare(tag);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (cur.flush) m_ll = 0;
            else if (m_wb.llset) m_ll = 1;
            else if (m_wb.llclr) m_ll = 0;
            if (m_wb.whilo && !cur.flush) begin
                m_hi = m_wb.hi;
                m_lo = m_wb.lo;
            end
            if (cur.flush || (cur.stall_mem && !cur.stall_wb)) m_wb = idle();
            else if (!cur.stall_mem) m_wb = cur;
        end
    endtask

    task automatic run(input in_t t, input string tag);
        drive(t, tag);
        tick();
    endtask

    initial begin
        in_t t;
        bit [31:0] ld_rd;
        model_reset();
        cur = idle();
        drive(idle(), "rst_hold");
        tick();
        @(negedge clk);
        rst = 1'b0;
        #1;
        compare("rst_rel");
        tick();

        // ALU write
        t = idle(); t.wreg = 1; t.wd = 5'h08; t.wdata = 32'h1234_5678;
        run(t, "alu_in");
        drive(idle(), "alu_wb");
        chk("alu.we", 32'(bus.wb_we), 32'd1);
        chk("alu.waddr", 32'(bus.wb_waddr), 32'd8);
        chk("alu.wdata", bus.wb_wdata, 32'h1234_5678);
        tick();

        // Load extraction table
        ld_rd = 32'h80FF_7F01;
        begin
            bit [2:0]  lts[6] = '{3'd1, 3'd2, 3'd3, 3'd3, 3'd4, 3'd5};
            bit [1:0]  bas[6] = '{2'd2, 2'd3, 2'd0, 2'd2, 2'd2, 2'd1};
            bit [31:0] exs[6] = '{32'hFFFF_FFFF, 32'h0000_0080, 32'h0000_7F01,
                                  32'hFFFF_80FF, 32'h0000_80FF, 32'h80FF_7F01};
            for (int i = 0; i < 6; i++) begin
                t = idle(); t.wreg = 1; t.wd = 5'(i + 1); t.ltype = lts[i]; t.baddr = bas[i];
                t.wdata = 32'hDEAD_BEEF;
                run(t, "ld_in");
                t = idle(); t.rdata = ld_rd;
                drive(t, "ld_wb");
                chk($sformatf("load%0d", i), bus.wb_wdata, exs[i]);
                tick();
            end
        end

        // Stall hold then stall bubble
        t = idle(); t.wreg = 1; t.wd = 5'h11; t.wdata = 32'hCAFE_0001;
        run(t, "st_in");
        for (int i = 0; i < 3; i++) begin
            t = idle(); t.stall_mem = 1; t.stall_wb = 1; t.wreg = 1; t.wd = 5'h1F; t.wdata = 32'h5555_5555;
            drive(t, "st_hold");
            chk("hold.waddr", 32'(bus.wb_waddr), 32'h11);
            chk("hold.wdata", bus.wb_wdata, 32'hCAFE_0001);
            tick();
        end
        t = idle(); t.stall_mem = 1; t.wreg = 1; t.wd = 5'h1F;
        run(t, "st_bub_in");
        drive(idle(), "st_bub");
        chk("bubble.we", 32'(bus.wb_we), 32'd0);
        tick();

        // LL / SC / LL+flush
        t = idle(); t.llset = 1; t.wreg = 1; t.wd = 5'h02;
        run(t, "ll_in");
        drive(idle(), "ll_wb");
        chk("ll.same", 32'(bus.llbit_o), 32'd1);
        tick();
        drive(idle(), "ll_keep");
        chk("ll.keep", 32'(bus.llbit_o), 32'd1);
        tick();
        t = idle(); t.llclr = 1;
        run(t, "sc_in");
        drive(idle(), "sc_wb");
        chk("sc.clr", 32'(bus.llbit_o), 32'd0);
        tick();
        t = idle(); t.llset = 1;
        run(t, "llf_in");
        t = idle(); t.flush = 1;
        drive(t, "llf_flush");
        chk("llflush.o", 32'(bus.llbit_o), 32'd0);
        tick();
        drive(idle(), "llf_after");
        chk("llflush.bit", 32'(bus.llbit_o), 32'd0);
        tick();

`ifdef WB_HILO_EN
        t = idle(); t.whilo = 1; t.hi = 32'hA; t.lo = 32'hB;
        run(t, "hl_in");
        drive(idle(), "hl_wb");
        chk("hilo.hi", bus.hi_o, 32'hA);
        chk("hilo.lo", bus.lo_o, 32'hB);
        tick();
        drive(idle(), "hl_after");
        chk("hilo.hi2", bus.hi_o, 32'hA);
        tick();
        t = idle(); t.whilo = 1; t.hi = 32'h77; t.lo = 32'h88;
        run(t, "hlf_in");
        t = idle(); t.flush = 1;
        run(t, "hlf_flush");
        drive(idle(), "hlf_after");
        chk("hiloflush.hi", bus.hi_o, 32'hA);
        chk("hiloflush.lo", bus.lo_o, 32'hB);
        tick();
`endif

        // Async reset mid-cycle while stalled, then normal capture
        t = idle(); t.wreg = 1; t.wd = 5'h09; t.llset = 1; t.wdata = 32'h0BAD_F00D;
        run(t, "rs_in");
        t = idle(); t.stall_mem = 1; t.stall_wb = 1;
        drive(t, "rs_stall");
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        compare("rst_async");
        tick();
        @(negedge clk);
        rst = 1'b0;
        t = idle(); t.wreg = 1; t.wd = 5'h0C; t.wdata = 32'h0000_00C0;
        run(t, "rs_cap");
        drive(idle(), "rs_wb");
        chk("rst.capture", 32'(bus.wb_waddr), 32'h0C);
        tick();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            t = idle();
            t.stall_mem = ($urandom_range(0, 3) == 0);
            t.stall_wb  = t.stall_mem && ($urandom_range(0, 1) == 0);
            t.flush     = ($urandom_range(0, 15) == 0);
            t.wreg  = 1'($urandom);
            t.wd    = 5'($urandom);
            t.wdata = $urandom;
            t.ltype = 3'($urandom_range(0, 7));
            t.baddr = 2'($urandom);
            t.llset = ($urandom_range(0, 7) == 0);
            t.llclr = ($urandom_range(0, 7) == 0);
            t.rdata = $urandom;
            t.whilo = 1'($urandom);
            t.hi    = $urandom;
            t.lo    = $urandom;
            run(t, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
